// File: rtl/level_loader_if.sv
// level_loader_if: levels ROM read port and tile RAM write port seen by the level loader.
interface level_loader_if;
   logic        rom_cs;
   logic        rom_read;
   logic [29:0] rom_address;
   logic [7:0]  rom_data_in;
   logic        ram_write;
   logic [9:0]  ram_address;
   logic [7:0]  ram_data_out;
   logic        ram_grant;
   modport master (
      output rom_cs, rom_read, rom_address, ram_write, ram_address, ram_data_out,
      input  rom_data_in, ram_grant
   );
   modport slave (
      input  rom_cs, rom_read, rom_address, ram_write, ram_address, ram_data_out,
      output rom_data_in, ram_grant
   );
endinterface

// File: rtl/level_loader.sv
// level_loader: copies one 32x32 level from the levels ROM into tile RAM,
// scanning for the player start tile and counting diamonds on the way.
module level_loader #(
   parameter logic [7:0]  PLAYER_TILE  = 8'h05,
   parameter logic [7:0]  DIAMOND_TILE = 8'h04,
   parameter logic [29:0] ROM_BASE     = 30'h0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  level,
   output logic        busy,
   output logic        done,
   output logic [4:0]  player_x,
   output logic [4:0]  player_y,
   output logic        player_found,
   output logic [10:0] diamond_count,
   level_loader_if.master bus
);
   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
   state_t      state, state_nx;
   logic [2:0]  level_q;
   logic [9:0]  rd_idx;
   logic        stall;
   logic        accept;
   always_ff @(posedge clock) begin
      state <= !reset_n ? IDLE : state_nx;
   end
   always_comb begin
      state_nx        = state;
      stall           = bus.ram_write & ~bus.ram_grant;
      accept          = bus.ram_write & bus.ram_grant;
      bus.rom_cs      = state == FILL;
      bus.rom_read    = state == FILL && !stall;
      bus.rom_address = state == FILL ? ROM_BASE + {17'd0, level_q, rd_idx} : '0;
      case (state)
         IDLE:    state_nx = start ? FILL : IDLE;
         FILL:    state_nx = (!stall && rd_idx == 10'h3ff) ? DRAIN : FILL;
         DRAIN:   state_nx = bus.ram_grant ? DONE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   // ROM data captured on the falling edge is registered straight into the RAM write port.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         level_q          <= '0;
         rd_idx           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         bus.ram_write    <= 1'b0;
         bus.ram_address  <= '0;
         bus.ram_data_out <= '0;
         player_found     <= 1'b0;
         player_x         <= '0;
         player_y         <= '0;
         diamond_count    <= '0;
      end else begin
         done <= state == DONE;
         if (state == DONE) busy <= 1'b0;
         if (state == IDLE && start) begin
            level_q       <= level;
            rd_idx        <= '0;
            busy          <= 1'b1;
            player_found  <= 1'b0;
            player_x      <= '0;
            player_y      <= '0;
            diamond_count <= '0;
         end
         if (state == FILL && !stall) begin
            bus.ram_write    <= 1'b1;
            bus.ram_address  <= rd_idx;
            bus.ram_data_out <= bus.rom_data_in;
            rd_idx           <= rd_idx + 10'd1;
         end else if (accept) begin
            bus.ram_write <= 1'b0;
         end
         if (accept && bus.ram_data_out == PLAYER_TILE) begin
            player_found <= 1'b1;
            player_x     <= bus.ram_address[4:0];
            player_y     <= bus.ram_address[9:5];
         end
         if (accept && bus.ram_data_out == DIAMOND_TILE) diamond_count <= diamond_count + 11'd1;
      end
   end
endmodule

// File: tb/tb_level_loader.sv
// tb_level_loader: randomized level loads checked against a tile-list model of the ROM.
module tb_level_loader;
   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  level;
   logic        busy, done, player_found;
   logic [4:0]  player_x, player_y;
   logic [10:0] diamond_count;
   logic [7:0]  rom [0:8191];
   logic [9:0]  q_addr [$];
   logic [7:0]  q_data [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_edges;
   bit          timed_out;

   level_loader_if bus ();

   level_loader dut (
      .clock(clock), .reset_n(reset_n), .start(start), .level(level),
      .busy(busy), .done(done), .player_x(player_x), .player_y(player_y),
      .player_found(player_found), .diamond_count(diamond_count), .bus(bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (bus.rom_cs && bus.rom_read) bus.rom_data_in <= rom[bus.rom_address[12:0]];

   function automatic void model_load(input int lvl, output bit f, output int x, output int y, output int c);
      f = 0; x = 0; y = 0; c = 0;
      for (int i = 0; i < 1024; i++) begin
         if (rom[lvl*1024+i] == 8'h05) begin f = 1; x = i % 32; y = i / 32; end
         if (rom[lvl*1024+i] == 8'h04) c++;
      end
   endfunction

   // mode 0: grant always, 1: repeating 1,0,0,1, 2: random
   task automatic run_load(input int lvl, input int mode, input int inj_n, input int inj_lvl, input int rst_writes);
      bit st_prev = 0;
      logic [9:0] st_addr;
      logic [7:0] st_data;
      q_addr.delete(); q_data.delete();
      timed_out = 0; n_edges = 0;
      @(negedge clock);
      start = 1; level = 3'(lvl); bus.ram_grant = 1;
      @(posedge clock); #1;
      while (1) begin
         start = (n_edges == inj_n);
         if (n_edges == inj_n) level = 3'(inj_lvl);
         bus.ram_grant = mode == 0 ? 1'b1 : mode == 1 ? (n_edges % 4 == 0 || n_edges % 4 == 3) : 1'($urandom_range(0, 1));
         @(negedge clock);
         n_checks++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during_load edge %0d: got %b want 1", n_edges, busy); end
         if (st_prev) begin
            n_checks++;
            if (bus.ram_address !== st_addr || bus.ram_data_out !== st_data) begin
               n_fail++; $display("FAIL stall_hold: got %0d/%h want %0d/%h", bus.ram_address, bus.ram_data_out, st_addr, st_data);
            end
         end
         st_prev = bus.ram_write && !bus.ram_grant;
         if (st_prev) begin
            st_addr = bus.ram_address; st_data = bus.ram_data_out;
            n_checks++;
            if (bus.rom_read !== 1'b0) begin n_fail++; $display("FAIL stall_rom_read: got %b want 0", bus.rom_read); end
         end
         if (bus.ram_write && bus.ram_grant) begin q_addr.push_back(bus.ram_address); q_data.push_back(bus.ram_data_out); end
         if (rst_writes >= 0 && q_addr.size() == rst_writes) begin
            reset_n = 0; start = 0;
            @(posedge clock); #1;
            return;
         end
         @(posedge clock); n_edges++; #1;
         if (done === 1'b1) break;
         if (n_edges > 6000) begin
            timed_out = 1; n_checks++; n_fail++;
            $display("FAIL load_timeout: no done after %0d edges", n_edges);
            break;
         end
      end
      start = 0;
   endtask

   task automatic test_reset;
      reset_n = 0; start = 0; level = 0; bus.ram_grant = 1;
      repeat (2) @(posedge clock); #1;
      n_checks++;
      if ({busy, done, bus.rom_cs, bus.rom_read, bus.ram_write, player_found} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, bus.rom_cs, bus.rom_read, bus.ram_write, player_found});
      end
      n_checks++;
      if (bus.ram_address !== 10'd0 || bus.ram_data_out !== 8'd0) begin
         n_fail++; $display("FAIL reset_ram: got %0d/%h want 0/00", bus.ram_address, bus.ram_data_out);
      end
      n_checks++;
      if (player_x !== 5'd0 || player_y !== 5'd0 || diamond_count !== 11'd0) begin
         n_fail++; $display("FAIL reset_scan: got %0d,%0d,%0d want 0,0,0", player_x, player_y, diamond_count);
      end
      reset_n = 1;
   endtask

   task automatic test_level2_seq;
      bit f; int x, y, c, bad;
      for (int i = 0; i < 1024; i++) rom[2048+i] = 8'(i);
      run_load(2, 0, -1, 0, -1);
      n_checks++;
      if (n_edges != 1026) begin n_fail++; $display("FAIL done_latency: got %0d want 1026", n_edges); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy); end
      bad = (q_addr.size() != 1024);
      foreach (q_addr[i]) if (q_addr[i] !== 10'(i) || q_data[i] !== rom[2048+i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL l2_writes: got %0d writes, %0d bad want 1024, 0 bad", q_addr.size(), bad); end
      model_load(2, f, x, y, c);
      n_checks++;
      if (player_found !== f || player_x !== 5'(x) || player_y !== 5'(y) || diamond_count !== 11'(c)) begin
         n_fail++; $display("FAIL l2_scan: got %b %0d %0d %0d want %b %0d %0d %0d", player_found, player_x, player_y, diamond_count, f, x, y, c);
      end
      @(posedge clock); #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
   endtask

   task automatic test_backpressure;
      int bad;
      run_load(2, 1, -1, 0, -1);
      bad = (q_addr.size() != 1024);
      foreach (q_addr[i]) if (q_addr[i] !== 10'(i) || q_data[i] !== rom[2048+i]) bad++;
      n_checks++;
      if (bad != 0 || timed_out) begin n_fail++; $display("FAIL bp_writes: got %0d writes, %0d bad want 1024, 0 bad", q_addr.size(), bad); end
      n_checks++;
      if (n_edges <= 1026) begin n_fail++; $display("FAIL bp_latency: got %0d want >1026", n_edges); end
   endtask

   task automatic test_scan_player;
      int bad;
      for (int i = 0; i < 1024; i++) rom[5120+i] = 8'($urandom_range(6, 255));
      rom[5120+37] = 8'h05; rom[5120+1000] = 8'h05;
      rom[5120+0] = 8'h04; rom[5120+200] = 8'h04; rom[5120+511] = 8'h04; rom[5120+999] = 8'h04; rom[5120+1023] = 8'h04;
      run_load(5, 2, -1, 0, -1);
      n_checks++;
      if (player_found !== 1'b1 || player_x !== 5'd8 || player_y !== 5'd31 || diamond_count !== 11'd5) begin
         n_fail++; $display("FAIL player_scan: got %b %0d %0d %0d want 1 8 31 5", player_found, player_x, player_y, diamond_count);
      end
      bad = (q_addr.size() != 1024);
      foreach (q_addr[i]) if (q_addr[i] !== 10'(i) || q_data[i] !== rom[5120+i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL l5_writes: got %0d writes, %0d bad want 1024, 0 bad", q_addr.size(), bad); end
   endtask

   task automatic test_all_diamond;
      for (int i = 0; i < 1024; i++) rom[7168+i] = 8'h04;
      run_load(7, 1, -1, 0, -1);
      n_checks++;
      if (player_found !== 1'b0 || diamond_count !== 11'd1024) begin
         n_fail++; $display("FAIL all_diamond: got %b %0d want 0 1024", player_found, diamond_count);
      end
   endtask

   task automatic test_start_ignored;
      bit f; int x, y, c, bad;
      run_load(1, 2, 100, 6, -1);
      bad = (q_addr.size() != 1024);
      foreach (q_addr[i]) if (q_addr[i] !== 10'(i) || q_data[i] !== rom[1024+i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL start_ignored_writes: got %0d writes, %0d bad want 1024, 0 bad", q_addr.size(), bad); end
      model_load(1, f, x, y, c);
      n_checks++;
      if (player_found !== f || player_x !== 5'(x) || player_y !== 5'(y) || diamond_count !== 11'(c)) begin
         n_fail++; $display("FAIL start_ignored_scan: got %b %0d %0d %0d want %b %0d %0d %0d", player_found, player_x, player_y, diamond_count, f, x, y, c);
      end
      run_load(6, 0, -1, 0, -1);
      bad = (q_addr.size() != 1024);
      foreach (q_addr[i]) if (q_addr[i] !== 10'(i) || q_data[i] !== rom[6144+i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL relatch_writes: got %0d writes, %0d bad want 1024, 0 bad", q_addr.size(), bad); end
      model_load(6, f, x, y, c);
      n_checks++;
      if (player_found !== f || diamond_count !== 11'(c)) begin
         n_fail++; $display("FAIL relatch_scan: got %b %0d want %b %0d", player_found, diamond_count, f, c);
      end
   endtask

   task automatic test_reset_mid_fill;
      int bad;
      for (int i = 0; i < 1024; i++) rom[3072+i] = 8'($urandom_range(3, 6));
      run_load(3, 1, -1, 0, 300);
      n_checks++;
      if (q_addr.size() != 300) begin n_fail++; $display("FAIL pre_reset_writes: got %0d want 300", q_addr.size()); end
      n_checks++;
      if ({busy, done, bus.rom_cs, bus.rom_read, bus.ram_write, player_found} !== 6'b0) begin
         n_fail++; $display("FAIL midreset_ctrl: got %b want 000000", {busy, done, bus.rom_cs, bus.rom_read, bus.ram_write, player_found});
      end
      n_checks++;
      if (bus.ram_address !== 10'd0 || bus.ram_data_out !== 8'd0 || player_x !== 5'd0 || player_y !== 5'd0 || diamond_count !== 11'd0) begin
         n_fail++; $display("FAIL midreset_data: got %0d %h %0d %0d %0d want 0 00 0 0 0", bus.ram_address, bus.ram_data_out, player_x, player_y, diamond_count);
      end
      reset_n = 1;
      run_load(3, 0, -1, 0, -1);
      bad = (q_addr.size() != 1024);
      foreach (q_addr[i]) if (q_addr[i] !== 10'(i) || q_data[i] !== rom[3072+i]) bad++;
      n_checks++;
      if (bad != 0 || n_edges != 1026) begin
         n_fail++; $display("FAIL reload_after_reset: got %0d writes, %0d bad, %0d edges want 1024, 0, 1026", q_addr.size(), bad, n_edges);
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
      test_reset();
      test_level2_seq();
      test_backpressure();
      test_scan_player();
      test_all_diamond();
      test_start_ignored();
      test_reset_mid_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/level_loader.md
Name: level_loader

Overview:
Sequences a level copy from the levels ROM (8 levels × 32×32 one-byte tiles) into the tile RAM.
- On a start request it streams all 1024 tiles of the selected level at one tile per clock.
- It stalls on write-side backpressure.
- As the tiles pass through, it scans them for the player start tile and counts diamond tiles, so the game engine has these values once the load is done.
- It sits between the CPU-visible level-select register, the levels ROM and the tile RAM arbiter.

Parameters:
PLAYER_TILE, 8'h05, tile code marking the player start position
DIAMOND_TILE, 8'h04, tile code counted as a diamond
ROM_BASE, 30'h0, word address of level 0 in the levels ROM; level n starts at ROM_BASE + n*1024

Ports:
clock  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
start  in  1  load request, sampled only in IDLE
level  in  3  level number, latched when start is accepted
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the final tile write is accepted
rom_cs  out  1  levels ROM chip select
rom_read  out  1  levels ROM read strobe
rom_address  out  30  levels ROM word address (address[31:2])
rom_data_in  in  8  levels ROM data; registered in the ROM on the falling clock edge
ram_write  out  1  tile RAM write request
ram_address  out  10  tile index, y*32+x
ram_data_out  out  8  tile byte to write
ram_grant  in  1  tile RAM accepts the write this cycle when ram_write is high
player_x  out  5  x of the last PLAYER_TILE seen
player_y  out  5  y of the last PLAYER_TILE seen
player_found  out  1  at least one PLAYER_TILE seen in this load
diamond_count  out  11  number of DIAMOND_TILE tiles in this load, 0..1024

Behaviour:
- Reset (reset_n low at a rising edge, from any state, including mid-load):
  - State goes to IDLE.
  - All outputs are 0: busy, done, rom_cs, rom_read, ram_write, ram_address, ram_data_out, player_x, player_y, player_found, diamond_count.
  - The read index is cleared; any partial load is abandoned.
- State machine: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - On start=1: latch level, clear rd_idx, player_found, player_x, player_y and diamond_count, set busy, go to FILL.
  - start is ignored in every other state.
- stall = ram_write & ~ram_grant (combinational).
- FILL:
  - rom_cs = 1.
  - rom_read = ~stall.
  - rom_address = ROM_BASE + {level, rd_idx}, with rd_idx 10 bits.
  - The ROM captures at the mid-cycle falling edge, so rom_data_in is valid at the next rising edge.
  - At a rising edge with ~stall:
    - ram_write <= 1, ram_address <= rd_idx, ram_data_out <= rom_data_in.
    - rd_idx increments.
    - When rd_idx was 1023, go to DRAIN.
  - With stall: every register holds. The ROM output also holds because rom_read is 0.
- DRAIN:
  - rom_cs = rom_read = 0.
  - ram_write is held until ram_grant, then cleared.
  - The next state is DONE.
- DONE:
  - done = 1 for exactly one cycle; busy is cleared in the same cycle.
  - The next state is IDLE.
- ROM strobes are combinational from state, level and rd_idx. The RAM-side outputs are registered.
- Scan, on every accepted write (ram_write & ram_grant):
  - If ram_data_out == PLAYER_TILE: player_found <= 1, player_x <= ram_address[4:0], player_y <= ram_address[9:5]. On multiple occurrences, the last one wins.
  - If ram_data_out == DIAMOND_TILE: diamond_count increments. 11 bits, so no saturation is needed.
- Scan results are valid from the done pulse and held until the next accepted start.
- Writes are issued in strictly ascending address order 0..1023. Each address is written exactly once per load.
- Throughput: with ram_grant tied high, one write per cycle. done rises on the 1026th rising edge after the edge that accepts start.
- level wraps naturally within 3 bits; no range check.

Test Plan:
- Reset mid-FILL (after 300 writes) → next cycle all outputs 0 and state IDLE; a new start then reloads from tile 0.
- Level 2, levels.txt filled with byte = index[7:0], ram_grant=1 → 1024 writes, ram_address 0..1023 with data matching ROM[2048+i], done on edge 1026, busy low with done.
- Same load with ram_grant toggled (1,0,0,1 pattern) → identical write sequence with no duplicate or missing addresses; stalled cycles show rom_read=0 and stable ram_address/ram_data_out.
- Level with PLAYER_TILE at tiles 37 and 1000 and DIAMOND_TILE at 5 tiles → player_x=8, player_y=31, player_found=1, diamond_count=5 at done.
- Level with no PLAYER_TILE and every tile DIAMOND_TILE → player_found=0, diamond_count=1024.
- start pulsed during FILL with a different level → ignored; the load completes for the original level and level re-latches only on the next IDLE start.
